// File: rtl/text_feed_sequencer.sv
// Byte-stream front end for the random-index encoder: maps ASCII to letter indices and sequences
// one text per language. Define UPPERCASE_FOLD_EN to fold 'A'..'Z' onto the lowercase letters.
module text_feed_sequencer #(
    parameter int MAXLETTERS   = 27,
    parameter int NUMLANG      = 22,
    parameter int LETTER_W     = 5,
    parameter int LANG_W       = 5,
    parameter int CNT_W        = 24,
    parameter int GAP          = 0,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                byte_last,
    output logic                byte_ready,
    output logic                letter_ready,
    output logic [LETTER_W-1:0] input_letter,
    output logic                text_done,
    output logic                enc_rst_n,
    output logic [LANG_W-1:0]   lang_sel,
    output logic                lang_done,
    output logic [CNT_W-1:0]    letter_cnt,
    output logic [CNT_W-1:0]    unknown_cnt,
    output logic                all_done,
    output logic [2:0]          state_dbg
);
    // Handshake: a byte transfers on a clk edge where byte_valid & byte_ready are both high;
    // byte_ready is registered, so the source sees it a full cycle ahead and holds data while it is low.
    typedef enum logic [2:0] {
        S_IDLE, S_OPEN, S_STREAM, S_CLOSE, S_DRAIN, S_FIN
    } state_t;

    localparam int GAP_W   = (GAP > 0) ? $clog2(GAP + 1) : 1;
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    state_t                state_q, state_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic                  last_q, last_d;
    logic                  byte_ready_q, byte_ready_d;
    logic                  letter_ready_q, letter_ready_d;
    logic [LETTER_W-1:0]   input_letter_q, input_letter_d;
    logic                  text_done_q, text_done_d;
    logic                  enc_rst_n_q, enc_rst_n_d;
    logic [LANG_W-1:0]     lang_sel_q, lang_sel_d;
    logic                  lang_done_q, lang_done_d;
    logic [CNT_W-1:0]      letter_cnt_q, letter_cnt_d;
    logic [CNT_W-1:0]      unknown_cnt_q, unknown_cnt_d;
    logic                  all_done_q, all_done_d;

    logic                  accept;
    logic                  is_space, is_lower, is_upper, is_letter;
    logic [LETTER_W-1:0]   mapped;

    always_comb begin
        is_space = (byte_data == 8'h20);
        is_lower = (byte_data >= 8'h61) && (byte_data <= 8'h7a);
`ifdef UPPERCASE_FOLD_EN
        is_upper = (byte_data >= 8'h41) && (byte_data <= 8'h5a);
`else
        is_upper = 1'b0;
`endif
        is_letter = is_space || is_lower || is_upper;
        mapped = '0;
        if (is_space)      mapped = LETTER_W'(MAXLETTERS - 1);
        else if (is_lower) mapped = LETTER_W'(byte_data - 8'h61);
        else if (is_upper) mapped = LETTER_W'(byte_data - 8'h41);
    end

    assign accept = byte_valid && byte_ready_q;

    always_comb begin
        state_d        = state_q;
        gap_d          = gap_q;
        drain_d        = drain_q;
        last_d         = last_q;
        byte_ready_d   = 1'b0;
        letter_ready_d = 1'b0;
        text_done_d    = 1'b0;
        lang_done_d    = 1'b0;
        input_letter_d = input_letter_q;
        enc_rst_n_d    = enc_rst_n_q;
        lang_sel_d     = lang_sel_q;
        letter_cnt_d   = letter_cnt_q;
        unknown_cnt_d  = unknown_cnt_q;
        all_done_d     = all_done_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    state_d       = S_OPEN;
                    lang_sel_d    = '0;
                    all_done_d    = 1'b0;
                    enc_rst_n_d   = 1'b0;
                    letter_cnt_d  = '0;
                    unknown_cnt_d = '0;
                end
            end
            S_OPEN: begin
                state_d      = S_STREAM;
                enc_rst_n_d  = 1'b1;
                gap_d        = '0;
                last_d       = 1'b0;
                byte_ready_d = 1'b1;
            end
            S_STREAM: begin
                // One extra STREAM cycle after the last byte keeps text_done behind its letter strobe.
                if (last_q) begin
                    state_d     = S_CLOSE;
                    text_done_d = 1'b1;
                end else begin
                    if (accept) begin
                        gap_d  = GAP_W'(GAP);
                        last_d = byte_last;
                        if (is_letter) begin
                            letter_ready_d = 1'b1;
                            input_letter_d = mapped;
                            if (letter_cnt_q != '1) letter_cnt_d = letter_cnt_q + CNT_W'(1);
                        end else if (unknown_cnt_q != '1) begin
                            unknown_cnt_d = unknown_cnt_q + CNT_W'(1);
                        end
                    end else if (gap_q != '0) begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                    byte_ready_d = !last_d && (gap_d == '0);
                end
            end
            S_CLOSE: begin
                state_d     = S_DRAIN;
                drain_d     = DRAIN_W'(DRAIN_CYCLES - 1);
                lang_done_d = (DRAIN_CYCLES == 1);
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    if (lang_sel_q == LANG_W'(NUMLANG - 1)) begin
                        state_d    = S_FIN;
                        all_done_d = 1'b1;
                    end else begin
                        state_d       = S_OPEN;
                        lang_sel_d    = lang_sel_q + LANG_W'(1);
                        enc_rst_n_d   = 1'b0;
                        letter_cnt_d  = '0;
                        unknown_cnt_d = '0;
                    end
                end else begin
                    drain_d     = drain_q - DRAIN_W'(1);
                    lang_done_d = (drain_q == DRAIN_W'(1));
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            gap_q          <= '0;
            drain_q        <= '0;
            last_q         <= 1'b0;
            byte_ready_q   <= 1'b0;
            letter_ready_q <= 1'b0;
            input_letter_q <= '0;
            text_done_q    <= 1'b0;
            enc_rst_n_q    <= 1'b0;
            lang_sel_q     <= '0;
            lang_done_q    <= 1'b0;
            letter_cnt_q   <= '0;
            unknown_cnt_q  <= '0;
            all_done_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            gap_q          <= gap_d;
            drain_q        <= drain_d;
            last_q         <= last_d;
            byte_ready_q   <= byte_ready_d;
            letter_ready_q <= letter_ready_d;
            input_letter_q <= input_letter_d;
            text_done_q    <= text_done_d;
            enc_rst_n_q    <= enc_rst_n_d;
            lang_sel_q     <= lang_sel_d;
            lang_done_q    <= lang_done_d;
            letter_cnt_q   <= letter_cnt_d;
            unknown_cnt_q  <= unknown_cnt_d;
            all_done_q     <= all_done_d;
        end
    end

    assign byte_ready   = byte_ready_q;
    assign letter_ready = letter_ready_q;
    assign input_letter = input_letter_q;
    assign text_done    = text_done_q;
    assign enc_rst_n    = enc_rst_n_q;
    assign lang_sel     = lang_sel_q;
    assign lang_done    = lang_done_q;
    assign letter_cnt   = letter_cnt_q;
    assign unknown_cnt  = unknown_cnt_q;
    assign all_done     = all_done_q;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_text_feed_sequencer.sv
// Self-checking bench for text_feed_sequencer: random byte streams against a letter-list model,
// plus a second instance with GAP=2 for throughput pacing.
module tb_text_feed_sequencer;
    localparam int NL = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, byte_valid = 1'b0, byte_last = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready, letter_ready, text_done, enc_rst_n, lang_done, all_done;
    logic [4:0]  input_letter, lang_sel;
    logic [23:0] letter_cnt, unknown_cnt;
    logic [2:0]  state_dbg;

    logic        g_start = 1'b0, g_byte_valid = 1'b0, g_byte_last = 1'b0;
    logic [7:0]  g_byte_data = 8'h00;
    logic        g_byte_ready, g_letter_ready, g_text_done, g_enc_rst_n, g_lang_done, g_all_done;
    logic [4:0]  g_input_letter, g_lang_sel;
    logic [23:0] g_letter_cnt, g_unknown_cnt;
    logic [2:0]  g_state_dbg;

    text_feed_sequencer #(.NUMLANG(NL)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(byte_ready), .letter_ready(letter_ready),
        .input_letter(input_letter), .text_done(text_done), .enc_rst_n(enc_rst_n),
        .lang_sel(lang_sel), .lang_done(lang_done), .letter_cnt(letter_cnt),
        .unknown_cnt(unknown_cnt), .all_done(all_done), .state_dbg(state_dbg)
    );

    text_feed_sequencer #(.NUMLANG(1), .GAP(2)) dut_gap (
        .clk(clk), .rst(rst), .start(g_start), .byte_valid(g_byte_valid), .byte_data(g_byte_data),
        .byte_last(g_byte_last), .byte_ready(g_byte_ready), .letter_ready(g_letter_ready),
        .input_letter(g_input_letter), .text_done(g_text_done), .enc_rst_n(g_enc_rst_n),
        .lang_sel(g_lang_sel), .lang_done(g_lang_done), .letter_cnt(g_letter_cnt),
        .unknown_cnt(g_unknown_cnt), .all_done(g_all_done), .state_dbg(g_state_dbg)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  txt[$];
    logic [4:0]  exp_q[$];
    logic [4:0]  last_letter = 5'd0;
    string       texts[NL];

    function automatic int ref_map(input logic [7:0] b);
        if (b == 8'h20) return 26;
        if (b >= 8'h61 && b <= 8'h7a) return int'(b) - 97;
`ifdef UPPERCASE_FOLD_EN
        if (b >= 8'h41 && b <= 8'h5a) return int'(b) - 65;
`endif
        return -1;
    endfunction

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h20;
            3:       return 8'($urandom_range(0, 127));
            default: return 8'(8'h61 + $urandom_range(0, 25));
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_text(input int l);
        txt.delete();
        if (texts[l].len() > 0) begin
            for (int i = 0; i < texts[l].len(); i++) txt.push_back(texts[l][i]);
        end else begin
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) txt.push_back(rand_byte());
        end
    endtask

    task automatic run_language(input int lang);
        int t, idx, n_unk, n_let;
        bit pend, acc, done;
        exp_q.delete();
        n_unk = 0;
        foreach (txt[i]) begin
            if (ref_map(txt[i]) >= 0) exp_q.push_back(5'(ref_map(txt[i])));
            else n_unk++;
        end
        n_let = exp_q.size();
        t = 0;
        while (enc_rst_n !== 1'b0 && t < 20) begin step(); t++; end
        checks++;
        if (enc_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL open_timeout lang=%0d enc_rst_n=%b required 0", lang, enc_rst_n);
            return;
        end
        checks++;
        if (lang_sel !== 5'(lang)) begin
            errors++; $display("FAIL open_lang_sel got=%0d required %0d", lang_sel, lang);
        end
        checks++;
        if (letter_cnt !== 24'd0 || unknown_cnt !== 24'd0) begin
            errors++; $display("FAIL open_cnt_clear got=%0d/%0d required 0/0", letter_cnt, unknown_cnt);
        end
        step();
        checks++;
        if (enc_rst_n !== 1'b1) begin
            errors++; $display("FAIL open_len enc_rst_n=%b required 1", enc_rst_n);
        end
        pend = 0; done = 0; idx = 0; t = 0;
        while (t < 300) begin
            checks++;
            if (letter_ready !== pend) begin
                errors++; $display("FAIL letter_strobe lang=%0d got=%b required %b", lang, letter_ready, pend);
            end
            if (pend) last_letter = exp_q.pop_front();
            checks++;
            if (input_letter !== last_letter) begin
                errors++; $display("FAIL letter_value lang=%0d got=%0d required %0d", lang, input_letter, last_letter);
            end
            checks++;
            if (text_done !== 1'b0) begin
                errors++; $display("FAIL text_done_early got=%b required 0", text_done);
            end
            if (done) break;
            checks++;
            if (byte_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready got=%b required 1", byte_ready);
            end
            byte_valid = ($urandom_range(0, 3) != 0);
            byte_data  = txt[idx];
            byte_last  = (idx == txt.size() - 1);
            start      = 1'($urandom_range(0, 1));
            acc  = byte_valid && byte_ready;
            pend = acc && (ref_map(txt[idx]) >= 0);
            if (acc) begin
                if (byte_last) done = 1;
                idx++;
            end
            step();
            t++;
        end
        byte_valid = 1'b0; byte_last = 1'b0; start = 1'b0;
        checks++;
        if (!done) begin
            errors++; $display("FAIL stream_timeout lang=%0d sent=%0d required %0d", lang, idx, txt.size());
            return;
        end
        checks++;
        if (byte_ready !== 1'b0) begin
            errors++; $display("FAIL ready_after_last got=%b required 0", byte_ready);
        end
        step();
        checks++;
        if (text_done !== 1'b1 || letter_ready !== 1'b0) begin
            errors++; $display("FAIL close_text_done got=%b/%b required 1/0", text_done, letter_ready);
        end
        step();
        checks++;
        if (lang_done !== 1'b1 || text_done !== 1'b0) begin
            errors++; $display("FAIL drain_lang_done got=%b/%b required 1/0", lang_done, text_done);
        end
        checks++;
        if (letter_cnt !== 24'(n_let) || unknown_cnt !== 24'(n_unk)) begin
            errors++; $display("FAIL text_counts lang=%0d got=%0d/%0d required %0d/%0d",
                               lang, letter_cnt, unknown_cnt, n_let, n_unk);
        end
    endtask

    task automatic run_texts();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int l = 0; l < NL; l++) begin
            load_text(l);
            run_language(l);
            step();
        end
        checks++;
        if (all_done !== 1'b1 || byte_ready !== 1'b0 || enc_rst_n !== 1'b1 || lang_sel !== 5'(NL - 1)) begin
            errors++; $display("FAIL fin_state got=%b/%b/%b/%0d required 1/0/1/%0d",
                               all_done, byte_ready, enc_rst_n, lang_sel, NL - 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({byte_ready, letter_ready, input_letter, text_done, enc_rst_n, lang_sel, lang_done,
             letter_cnt, unknown_cnt, all_done} !== 64'd0) begin
            errors++; $display("FAIL reset_outputs got=%h required 0", {byte_ready, letter_ready,
                input_letter, text_done, enc_rst_n, lang_sel, lang_done, letter_cnt, unknown_cnt, all_done});
        end
        rst = 1'b1;
        step();
        checks++;
        if (byte_ready !== 1'b0 || all_done !== 1'b0 || enc_rst_n !== 1'b0 || g_byte_ready !== 1'b0) begin
            errors++; $display("FAIL idle_outputs got=%b/%b/%b/%b required 0/0/0/0",
                               byte_ready, all_done, enc_rst_n, g_byte_ready);
        end
        last_letter = 5'd0;
    endtask

    task automatic test_fixed_run();
        texts[0] = "ab c"; texts[1] = "z"; texts[2] = "a1!b"; texts[3] = "#";
        run_texts();
    endtask

    task automatic test_random_run();
        texts[0] = "AbZ"; texts[1] = ""; texts[2] = ""; texts[3] = "";
        run_texts();
    endtask

    task automatic test_reset_mid_stream();
        int n, t;
        start = 1'b1; step(); start = 1'b0; step();
        n = 0; t = 0;
        byte_valid = 1'b1; byte_last = 1'b0;
        while (n < 5 && t < 50) begin
            byte_data = 8'(8'h61 + $urandom_range(0, 25));
            if (byte_ready) n++;
            step();
            t++;
        end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL mid_accept got=%0d required 5", n);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({byte_ready, letter_ready, input_letter, text_done, enc_rst_n, lang_sel, lang_done,
             letter_cnt, unknown_cnt, all_done} !== 64'd0) begin
            errors++; $display("FAIL mid_reset_outputs got=%h required 0", {byte_ready, letter_ready,
                input_letter, text_done, enc_rst_n, lang_sel, lang_done, letter_cnt, unknown_cnt, all_done});
        end
        step(); step();
        rst = 1'b1; byte_valid = 1'b0;
        step();
        checks++;
        if (byte_ready !== 1'b0 || enc_rst_n !== 1'b0 || letter_cnt !== 24'd0) begin
            errors++; $display("FAIL mid_reset_idle got=%b/%b/%0d required 0/0/0", byte_ready, enc_rst_n, letter_cnt);
        end
        last_letter = 5'd0;
    endtask

    task automatic test_gap();
        int n, first_c, last_c;
        bit pend;
        g_start = 1'b1; step(); g_start = 1'b0; step();
        g_byte_valid = 1'b1;
        n = 0; pend = 0; first_c = -1; last_c = -1;
        for (int c = 0; c < 14; c++) begin
            checks++;
            if (g_letter_ready !== pend) begin
                errors++; $display("FAIL gap_strobe cycle=%0d got=%b required %b", c, g_letter_ready, pend);
            end
            if (c == 11) begin
                checks++;
                if (g_text_done !== 1'b1) begin
                    errors++; $display("FAIL gap_text_done got=%b required 1", g_text_done);
                end
            end
            if (c == 12) begin
                checks++;
                if (g_lang_done !== 1'b1) begin
                    errors++; $display("FAIL gap_lang_done got=%b required 1", g_lang_done);
                end
            end
            if (n < 4) begin
                checks++;
                if (g_byte_ready !== (c % 3 == 0)) begin
                    errors++; $display("FAIL gap_ready_pattern cycle=%0d got=%b required %b",
                                       c, g_byte_ready, (c % 3 == 0));
                end
                g_byte_data = 8'(8'h61 + n);
                g_byte_last = (n == 3);
                pend = g_byte_ready;
                if (g_byte_ready) begin
                    if (n == 0) first_c = c;
                    last_c = c;
                    n++;
                end
            end else begin
                g_byte_valid = 1'b0; g_byte_last = 1'b0; pend = 0;
            end
            step();
        end
        g_byte_valid = 1'b0;
        checks++;
        if (n != 4 || last_c - first_c + 1 != 10) begin
            errors++; $display("FAIL gap_throughput got=%0d bytes in %0d cycles required 4 in 10",
                               n, last_c - first_c + 1);
        end
        checks++;
        if (g_all_done !== 1'b1 || g_letter_cnt !== 24'd4 || g_unknown_cnt !== 24'd0) begin
            errors++; $display("FAIL gap_fin got=%b/%0d/%0d required 1/4/0", g_all_done, g_letter_cnt, g_unknown_cnt);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fixed_run();
        test_random_run();
        test_reset_mid_stream();
        test_random_run();
        test_gap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
